// File: rtl/serial_ula_n.sv
// Bit-serial AND/OR/ADD/SUB unit. One 1-bit slice runs over WIDTH bits, LSB first,
// one bit per clock. A start/busy/done handshake controls it.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request; accepted in IDLE or DONE
//   A, B            operands, latched on an accepted start
//   carryIn         carry / no-borrow in, latched on an accepted start
//   op              00 AND, 01 OR, 10 ADD, 11 SUB, latched on an accepted start
//   C               result, held until the next completion
//   carryOut        final carry (ADD/SUB), 0 for logic ops
//   zero            C == 0
//   overflow        signed overflow (ADD/SUB), 0 for logic ops
//   busy            high while the operation runs
//   done            one-cycle completion pulse
module serial_ula_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carryIn,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] C,
    output logic             carryOut,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpSub = 2'b11;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
    logic [1:0]       op_q;
    logic             cy_q, cy_next;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, last_bit, b_bit, r_bit;

    // A start in DONE is accepted just like in IDLE, giving back-to-back operation.
    assign accept   = start && (state_q != StRun);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    // Bit slice operating on the current LSB of the operand shift registers
    always_comb begin
        b_bit   = (op_q == OpSub) ? ~b_q[0] : b_q[0];
        r_bit   = 1'b0;
        cy_next = cy_q;
        case (op_q)
            OpAnd: r_bit = a_q[0] & b_bit;
            OpOr:  r_bit = a_q[0] | b_bit;
            default: begin
                r_bit   = a_q[0] ^ b_bit ^ cy_q;
                cy_next = (a_q[0] & b_bit) | (a_q[0] & cy_q) | (b_bit & cy_q);
            end
        endcase
        // Result bits enter at the MSB so that the LSB lands in bit 0 after WIDTH shifts.
        res_next            = res_q >> 1;
        res_next[WIDTH-1]   = r_bit;
    end

    // Datapath: operand latches, shadow result and the visible result and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            op_q     <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            C        <= '0;
            carryOut <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op;
            cy_q  <= carryIn;
            cnt_q <= '0;
            res_q <= '0;
        end else if (state_q == StRun) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            cy_q  <= cy_next;
            res_q <= res_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                C        <= res_next;
                zero     <= (res_next == '0);
                // op_q[1] marks ADD/SUB; cy_q here is the carry into the MSB.
                carryOut <= op_q[1] & cy_next;
                overflow <= op_q[1] & (cy_q ^ cy_next);
            end
        end
    end

endmodule
